// File: rtl/wb_slv_mem.sv
// wb_slv_mem: Wishbone slave RAM with byte lanes, wait states and err/rty injection
module wb_slv_mem #(
  parameter int          mem_aw   = 10,
  parameter logic [31:0] base_adr = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        cyc,
  input  logic        stb,
  input  logic [3:0]  sel,
  input  logic        we,
  output logic        ack,
  output logic        err,
  output logic        rty,
  input  logic [3:0]  wait_cnt,
  input  logic        rty_req
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [mem_aw-1:0] l_idx, e_idx;
  logic [31:0] l_din, e_din;
  logic [3:0] l_sel, e_sel;
  logic l_we, l_oor, l_rty, e_we, e_oor, e_rty;
  logic accept, go_resp, e_ack;
  logic [31:0] mem [2**mem_aw];
  logic unused_ok;
  assign unused_ok = &{1'b0, adr[1:0]};
  // with no wait states the access terminates on the accept edge, so live inputs are used there
  always_comb begin
    accept   = state == IDLE && cyc && stb;
    go_resp  = (accept && wait_cnt == 4'd0) || (state == WAIT && cyc && cnt == 4'd1);
    state_nx = state == RESP ? IDLE :
               accept ? (wait_cnt == 4'd0 ? RESP : WAIT) :
               state == WAIT ? (!cyc ? IDLE : cnt == 4'd1 ? RESP : WAIT) : IDLE;
    e_idx    = state == IDLE ? adr[mem_aw+1:2] : l_idx;
    e_din    = state == IDLE ? din : l_din;
    e_sel    = state == IDLE ? sel : l_sel;
    e_we     = state == IDLE ? we : l_we;
    e_oor    = state == IDLE ? adr[31:mem_aw+2] != base_adr[31:mem_aw+2] : l_oor;
    e_rty    = state == IDLE ? rty_req : l_rty;
    e_ack    = go_resp && !e_oor && !e_rty;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      l_idx <= '0;
      l_din <= '0;
      l_sel <= '0;
      l_we  <= 1'b0;
      l_oor <= 1'b0;
      l_rty <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rty   <= 1'b0;
      dout  <= '0;
    end else begin
      cnt <= accept ? wait_cnt : state == WAIT ? cnt - 4'd1 : 4'd0;
      if (accept) begin
        l_idx <= e_idx;
        l_din <= e_din;
        l_sel <= e_sel;
        l_we  <= e_we;
        l_oor <= e_oor;
        l_rty <= e_rty;
      end
      ack  <= e_ack;
      err  <= go_resp && e_oor;
      rty  <= go_resp && !e_oor && e_rty;
      dout <= e_ack && !e_we ? mem[e_idx] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && e_ack && e_we)
      for (int i = 0; i < 4; i++)
        if (e_sel[i]) mem[e_idx][8*i+:8] <= e_din[8*i+:8];
  end
endmodule

// File: tb/tb_wb_slv_mem.sv
// tb_wb_slv_mem: directed bench with a per-cycle reference model of the slave memory
module tb_wb_slv_mem;
  localparam int AW = 10;
  localparam logic [31:0] BASE = 32'h0001_0000;
  logic clk = 0, rst = 0;
  logic [31:0] adr = 0, din = 0, dout;
  logic cyc = 0, stb = 0, we = 0, ack, err, rty, rty_req = 0;
  logic [3:0] sel = 0, wait_cnt = 0;
  int checks = 0, errors = 0;
  int ec = 0;
  int term_edge = -1;
  int kind = 0;
  logic [31:0] term_dout = 0;
  logic [31:0] mdl [1 << AW];
  logic [31:0] got;
  logic [2:0] seen;

  wb_slv_mem #(.mem_aw(AW), .base_adr(BASE)) dut (
    .clk(clk), .rst(rst), .adr(adr), .din(din), .dout(dout), .cyc(cyc), .stb(stb),
    .sel(sel), .we(we), .ack(ack), .err(err), .rty(rty), .wait_cnt(wait_cnt), .rty_req(rty_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec++;

  // model: the only termination allowed is the one scheduled for edge term_edge
  always @(negedge clk) begin
    logic ea, ee, er;
    logic [31:0] ed;
    ea = ec == term_edge && kind == 1;
    ee = ec == term_edge && kind == 2;
    er = ec == term_edge && kind == 3;
    ed = ea ? term_dout : 32'h0;
    checks++;
    if ({ack, err, rty, dout} !== {ea, ee, er, ed}) begin
      errors++;
      $display("FAIL cycle %0d: ack/err/rty/dout got %b%b%b %h want %b%b%b %h",
               ec, ack, err, rty, dout, ea, ee, er, ed);
    end
  end

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, input logic [3:0] wc, input logic rr, input int abort_after,
                        output logic [31:0] g, output logic [2:0] sn);
    int idx, k;
    @(negedge clk); #1;
    cyc = 1; stb = 1; adr = a; din = d; sel = s; we = w; wait_cnt = wc; rty_req = rr;
    idx = int'((a >> 2) % (1 << AW));
    k = ((a >> (AW + 2)) != (BASE >> (AW + 2))) ? 2 : rr ? 3 : 1;
    if (abort_after >= 0) begin
      term_edge = -1; kind = 0;
    end else begin
      term_edge = ec + 1 + int'(wc);
      kind = k;
      term_dout = (k == 1 && !w) ? mdl[idx] : 32'h0;
      if (k == 1 && w)
        for (int l = 0; l < 4; l++) if (s[l]) mdl[idx][8*l+:8] = d[8*l+:8];
    end
    @(negedge clk); #1;
    stb = 0; adr = ~a; din = ~d; sel = ~s; we = ~w; wait_cnt = 4'hf; rty_req = ~rr;
    if (abort_after >= 0) begin
      repeat (abort_after - 1) @(negedge clk);
      #1 cyc = 0;
      repeat (int'(wc) + 2) @(negedge clk);
      g = 0; sn = 0;
    end else begin
      if (wc != 0) begin
        repeat (int'(wc)) @(negedge clk);
        #1;
      end
      g = dout; sn = {ack, err, rty};
      cyc = 0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", {29'b0, ack, err, rty}, 32'h0);
    chk("reset_dout", dout, 32'h0);
    #1 rst = 1;
    access(BASE + 32'h10, 32'hdead_beef, 4'hf, 1, 0, 0, -1, got, seen);
    chk("wr_ack", {29'b0, seen}, 32'h4);
    access(BASE + 32'h10, 32'h0, 4'h0, 0, 0, 0, -1, got, seen);
    chk("rd_data", got, 32'hdead_beef);
    chk("rd_ack", {29'b0, seen}, 32'h4);
    access(BASE + 32'h14, 32'h1122_3344, 4'hf, 1, 0, 0, -1, got, seen);
    access(BASE + 32'h14, 32'haabb_ccdd, 4'b0101, 1, 0, 0, -1, got, seen);
    access(BASE + 32'h14, 32'h0, 4'h0, 0, 0, 0, -1, got, seen);
    chk("byte_lanes", got, 32'h11bb_33dd);
    access(BASE + 32'h14, 32'h0, 4'hf, 0, 3, 0, -1, got, seen);
    chk("wait3_data", got, 32'h11bb_33dd);
    chk("wait3_ack", {29'b0, seen}, 32'h4);
    access(BASE, 32'h0bad_f00d, 4'hf, 1, 0, 0, -1, got, seen);
    access(BASE + (32'd4 << AW), 32'h0, 4'hf, 1, 0, 0, -1, got, seen);
    chk("oor_err", {29'b0, seen}, 32'h2);
    access(BASE, 32'h0, 4'hf, 0, 0, 0, -1, got, seen);
    chk("oor_untouched", got, 32'h0bad_f00d);
    access(BASE + 32'h10, 32'h0, 4'hf, 1, 1, 1, -1, got, seen);
    chk("rty", {29'b0, seen}, 32'h1);
    access(BASE + 32'h10, 32'h0, 4'hf, 0, 0, 0, -1, got, seen);
    chk("rty_untouched", got, 32'hdead_beef);
    access(BASE + (32'd4 << AW), 32'h0, 4'hf, 0, 2, 1, -1, got, seen);
    chk("oor_rty_err", {29'b0, seen}, 32'h2);
    access(BASE + 32'h14, 32'hffff_ffff, 4'h0, 1, 0, 0, -1, got, seen);
    chk("sel0_ack", {29'b0, seen}, 32'h4);
    access(BASE + 32'h14, 32'h0, 4'h0, 0, 0, 0, -1, got, seen);
    chk("sel0_data", got, 32'h11bb_33dd);
    @(negedge clk); #1 cyc = 1; stb = 0;
    repeat (3) @(negedge clk);
    #1 cyc = 0; stb = 1;
    repeat (3) @(negedge clk);
    #1 stb = 0;
    access(BASE + 32'h20, 32'h5555_aaaa, 4'hf, 1, 0, 0, -1, got, seen);
    access(BASE + 32'h20, 32'h1234_5678, 4'hf, 1, 5, 0, 2, got, seen);
    access(BASE + 32'h20, 32'h0, 4'hf, 0, 0, 0, -1, got, seen);
    chk("abort_data", got, 32'h5555_aaaa);
    access(BASE + 32'h20, 32'h0, 4'hf, 0, 15, 0, -1, got, seen);
    chk("wait15_data", got, 32'h5555_aaaa);
    chk("wait15_ack", {29'b0, seen}, 32'h4);
    // async reset while a read is terminating
    @(negedge clk); #1;
    cyc = 1; stb = 1; adr = BASE + 32'h10; we = 0; sel = 4'hf; wait_cnt = 0; rty_req = 0;
    term_edge = ec + 1; kind = 1; term_dout = mdl[4];
    @(posedge clk); #2;
    chk("pre_rst_ack", {31'b0, ack}, 32'h1);
    chk("pre_rst_dout", dout, 32'hdead_beef);
    rst = 0; term_edge = -1; kind = 0;
    #1;
    chk("rst_resp_outs", {29'b0, ack, err, rty}, 32'h0);
    chk("rst_resp_dout", dout, 32'h0);
    cyc = 0; stb = 0;
    @(negedge clk); #1 rst = 1;
    // async reset in the middle of a waited write
    @(negedge clk); #1;
    cyc = 1; stb = 1; adr = BASE + 32'h20; din = 32'h1234_5678; we = 1; sel = 4'hf; wait_cnt = 5;
    @(posedge clk); @(posedge clk); #2;
    rst = 0;
    #1;
    chk("rst_wait_outs", {29'b0, ack, err, rty}, 32'h0);
    chk("rst_wait_dout", dout, 32'h0);
    cyc = 0; stb = 0;
    @(negedge clk); #1 rst = 1;
    access(BASE + 32'h20, 32'h0, 4'hf, 0, 0, 0, -1, got, seen);
    chk("rst_no_write", got, 32'h5555_aaaa);
    for (int i = 0; i < 4; i++) begin
      access(BASE + 32'h40 + 32'(4 * i), 32'hc0de_0000 + 32'(i), 4'hf, 1, 2, 0, -1, got, seen);
      chk("burst_wr_ack", {29'b0, seen}, 32'h4);
    end
    for (int i = 0; i < 4; i++) begin
      access(BASE + 32'h40 + 32'(4 * i), 32'h0, 4'hf, 0, 2, 0, -1, got, seen);
      chk("burst_rd", got, 32'hc0de_0000 + 32'(i));
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_slv_mem.md
# wb_slv_mem

Synthesizable Wishbone slave memory that sits directly downstream of the bench Wishbone master and the DMA core's master ports, completing their cyc/stb cycles with ack, err or rty. Word-organised RAM with byte-lane writes, programmable wait states, address-range error and retry injection. Used as the target memory in DMA bench configurations and as the reference slave for master-side protocol checks.

## Interface

- mem_aw, 10, word-address width; memory holds 2^mem_aw 32-bit words
- base_adr, 32'h0000_0000, base byte address; only bits [31:mem_aw+2] are compared
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- adr  input  32  byte address from master; word index = adr[mem_aw+1:2]
- din  input  32  write data from master
- dout  output  32  read data, valid while ack high
- cyc  input  1  bus cycle active
- stb  input  1  strobe, one access per assertion
- sel  input  4  byte lane enables; sel[i] covers bits [8i+7:8i]
- we  input  1  1 write, 0 read
- ack  output  1  normal termination
- err  output  1  error termination
- rty  output  1  retry termination
- wait_cnt  input  4  wait states inserted before termination, sampled at accept
- rty_req  input  1  request retry termination, sampled at accept

## Operation

- States: IDLE, WAIT, RESP.
- IDLE: on edge with cyc&stb=1, latch adr, din, sel, we, wait_cnt, rty_req; go WAIT if wait_cnt!=0, else RESP.
- WAIT: counter decrements once per edge; at counter==1 go RESP. cyc=0 at any edge -> IDLE, no response, no write.
- RESP: exactly one of ack/err/rty high for one cycle; next edge -> IDLE unconditionally (cyc/stb at that edge ignored).
- Priority at accept: out-of-range (adr[31:mem_aw+2] != base_adr[31:mem_aw+2]) -> err; else rty_req -> rty; else ack.
- Write with ack: lanes with sel[i]=1 updated on the edge entering RESP; sel=0 writes nothing but still acks. err/rty: memory untouched.
- Read with ack: dout = memory word, all 32 bits regardless of sel, registered on the edge entering RESP. dout=0 when err/rty/not RESP.
- Memory contents not reset; uninitialised words read X in simulation.

## Timing

- Reset (rst=0, asynchronous): state IDLE, ack=err=rty=0, dout=0, counter=0. Reset mid-access aborts it; no write performed.
- All outputs registered; no combinational path from inputs to outputs.
- Latency: cyc&stb first sampled at edge N -> termination high during cycle after edge N+wait_cnt, low after edge N+wait_cnt+1.
- Minimum access 2 cycles (accept + RESP); back-to-back accesses require master to drop stb or wait the forced IDLE cycle; max throughput one access per 2 cycles at wait_cnt=0.
- ack, err, rty mutually exclusive, never high two consecutive cycles.
- cyc=1, stb=0 in IDLE: no action. stb=1, cyc=0: ignored.
- Changes to adr/din/sel/we/wait_cnt/rty_req after accept have no effect on the current access.
- wait_cnt=15: termination 16 cycles after accept; counter never wraps.

## Test plan

- Write word: adr=base+0x10, sel=4'hf, din=32'hdead_beef, wait_cnt=0 -> ack one cycle after accept; read back same adr -> dout=32'hdead_beef with ack.
- Byte lanes: word preset 32'h1122_3344, write sel=4'b0101, din=32'haabb_ccdd -> readback 32'h11bb_33dd.
- Wait states: wait_cnt=3 read -> ack high in cycle after edge N+3, exactly one cycle; ack never seen earlier.
- Error/retry: adr=base+(4<<mem_aw) write -> err, memory unchanged; in-range write with rty_req=1 -> rty, word keeps old value; out-of-range with rty_req=1 -> err only.
- Abort: wait_cnt=5 write, drop cyc after 2 cycles -> no ack/err/rty, word unchanged; next access completes normally.
- Async reset: assert rst=0 mid-WAIT between clock edges -> ack/err/rty/dout 0 immediately; after release, 4-word bench burst with delay=2 completes with 4 acks and correct readback.
